// File: rtl/proc_run_controller_if.sv
// Board-side signal bundle for proc_run_controller: raw keys in, debounced keys
// and processor run-control outputs back.
interface proc_run_controller_if;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic       proc_reset_out;
  logic       proc_clk_en;
  logic       halted;
  logic [1:0] state_out;

  modport master (
    output key_in,
    input  key_out, proc_reset_out, proc_clk_en, halted, state_out
  );

  modport slave (
    input  key_in,
    output key_out, proc_reset_out, proc_clk_en, halted, state_out
  );
endinterface

// File: rtl/proc_run_controller.sv
// Key debouncer plus BOOT/RUN/HALT/STEP run-control FSM for a soft processor.
// Define RUNCTL_SINGLE_STEP_EN to enable single-stepping from HALT via KEY[1].
module proc_run_controller #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input logic                  clk,
  input logic                  reset,
  proc_run_controller_if.slave bus
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    STEP = 2'b11
  } state_t;

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       deb;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt [4];

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;

  logic ev_boot;
  logic ev_toggle;
`ifdef RUNCTL_SINGLE_STEP_EN
  logic ev_step;
`endif

  // Synchronize, debounce, and register a one-cycle pulse on each 1->0 accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      deb     <= '1;
      press   <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      sync_p0 <= bus.key_in;
      sync_p1 <= sync_p0;
      for (int k = 0; k < 4; k++) begin
        press[k] <= 1'b0;
        if (sync_p1[k] != deb[k]) begin
          if (cnt[k] == CNT_MAX) begin
            deb[k]   <= sync_p1[k];
            cnt[k]   <= '0;
            press[k] <= ~sync_p1[k];
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end else begin
          cnt[k] <= '0;
        end
      end
    end
  end

  // Priority decode of the registered pulses: KEY[3] > KEY[0] > KEY[1]; KEY[2] never acts
  always_comb begin
    ev_boot   = 1'b0;
    ev_toggle = 1'b0;
`ifdef RUNCTL_SINGLE_STEP_EN
    ev_step   = 1'b0;
`endif
    casez (press)
      4'b1???: ev_boot   = 1'b1;
      4'b0??1: ev_toggle = 1'b1;
`ifdef RUNCTL_SINGLE_STEP_EN
      4'b0?10: ev_step   = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      hold  <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = '0;
    if (ev_boot) begin
      state_next = BOOT;
    end else begin
      unique case (state)
        BOOT: begin
          if (hold == HOLD_MAX) state_next = RUN;
          else                  hold_next  = hold + 1'b1;
        end
        RUN:  if (ev_toggle) state_next = HALT;
        HALT: begin
          if (ev_toggle) state_next = RUN;
`ifdef RUNCTL_SINGLE_STEP_EN
          else if (ev_step) state_next = STEP;
`endif
        end
        STEP: state_next = HALT;
      endcase
    end
  end

  // Outputs decode only registered state so reset reaches them without a clock
  assign bus.key_out        = deb;
  assign bus.state_out      = state;
  assign bus.proc_reset_out = (state == BOOT);
  assign bus.proc_clk_en    = (state == RUN) || (state == STEP);
  assign bus.halted         = (state == HALT);

endmodule
